// File: rtl/ls_seq_pkg.sv
// ls_seq_pkg: shared constants for the load/store control sequencer.
//   - state encoding for the sequencer FSM (3-bit, legacy-compatible constants)
//   - supported opcodes OP_LW / OP_SW
//   - sign-extender selects IMM_I / IMM_S
//   - fault codes FC_NONE / FC_ILLEGAL / FC_TIMEOUT
//   - is_mem_wait(): true for states that hold a memory request open
package ls_seq_pkg;

   localparam logic [2:0] BOOT     = 3'd0;
   localparam logic [2:0] FETCH    = 3'd1;
   localparam logic [2:0] DECODE   = 3'd2;
   localparam logic [2:0] MEMADR   = 3'd3;
   localparam logic [2:0] MEMREAD  = 3'd4;
   localparam logic [2:0] MEMWB    = 3'd5;
   localparam logic [2:0] MEMWRITE = 3'd6;
   localparam logic [2:0] FAULT    = 3'd7;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;

   localparam logic IMM_I = 1'b0;
   localparam logic IMM_S = 1'b1;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;

   function automatic logic is_mem_wait(input logic [2:0] st);
      return (st == FETCH) || (st == MEMREAD) || (st == MEMWRITE);
   endfunction

endpackage

// File: rtl/ls_wait_timer.sv
// ls_wait_timer: counts consecutive cycles a memory request has waited.
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   run      in   a request is open and mem_ready is low this cycle
//   expired  out  this is the last tolerated wait cycle (count == TIMEOUT_CYCLES-1 while run)
// The count returns to zero whenever run drops. A request state is only left
// when mem_ready is high (run low) or on expiry, so this clears the count on
// every entry to FETCH, MEMREAD and MEMWRITE.
module ls_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign expired = run && (count == LAST);

endmodule

// File: rtl/ls_sequencer.sv
// ls_sequencer: multi-cycle control FSM for the load/store core
// (BOOT -> FETCH -> DECODE -> MEMADR -> MEMREAD -> MEMWB, or MEMADR -> MEMWRITE).
//   clk, rst     clock and synchronous active-high reset
//   op[6:0]      IR opcode field, stable from DECODE onward
//   mem_ready    memory completes the open request this cycle
//   mem_req      memory request valid
//   mem_we       1 = write, 0 = read
//   adr_src      memory address select: 0 = PC, 1 = ALUOut
//   ir_write     load IR (FETCH completion)
//   pc_write     PC <= PC + 4 (FETCH completion)
//   alu_src_b    ALU B operand: 0 = constant 4, 1 = Imm_Ext
//   imm_src      sign-extender select, registered in DECODE
//   reg_write    write memory data to rd
//   fault        sticky fault flag (FAULT state)
//   fault_code   00 none, 01 illegal opcode, 10 memory timeout
//   state_dbg    current FSM state, for checkers and debug
// Build option: define LS_TIMEOUT_EN to fault a request that waits
// TIMEOUT_CYCLES cycles without mem_ready; otherwise requests wait forever.
module ls_sequencer
   import ls_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       alu_src_b,
   output logic       imm_src,
   output logic       reg_write,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [2:0] state_dbg
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("ls_sequencer: TIMEOUT_CYCLES must be >= 2");
   end

   logic [2:0] state;
   logic [2:0] next_state;
   logic       decode_ok;
   logic       wait_expired;

   assign state_dbg = state;
   assign decode_ok = (op == OP_LW) || (op == OP_SW);

`ifdef LS_TIMEOUT_EN
   logic wait_run;
   assign wait_run = is_mem_wait(state) && !mem_ready;

   ls_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (wait_run),
      .expired (wait_expired)
   );
`else
   assign wait_expired = 1'b0;
`endif

   // Memory handshake: a transfer completes on a clock edge where mem_req and
   // mem_ready are both high. mem_req, mem_we and adr_src are decoded from the
   // state alone, so they cannot change until that edge (or reset/timeout,
   // which abandon the request). mem_ready is ignored while mem_req is low,
   // and ready in the first request cycle is a legal zero-wait completion.
   always_comb begin
      next_state = state;
      case (state)
         BOOT:     next_state = FETCH;
         FETCH: begin
            if (mem_ready)         next_state = DECODE;
            else if (wait_expired) next_state = FAULT;
         end
         DECODE:   next_state = decode_ok ? MEMADR : FAULT;
         // imm_src was loaded in DECODE and already tells LW from SW.
         MEMADR:   next_state = (imm_src == IMM_S) ? MEMWRITE : MEMREAD;
         MEMREAD: begin
            if (mem_ready)         next_state = MEMWB;
            else if (wait_expired) next_state = FAULT;
         end
         MEMWB:    next_state = FETCH;
         MEMWRITE: begin
            if (mem_ready)         next_state = FETCH;
            else if (wait_expired) next_state = FAULT;
         end
         FAULT:    next_state = FAULT;
         default:  next_state = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         imm_src    <= IMM_I;
         fault_code <= FC_NONE;
      end else begin
         state <= next_state;
         if (state == DECODE) begin
            imm_src <= (op == OP_SW) ? IMM_S : IMM_I;
            if (!decode_ok) fault_code <= FC_ILLEGAL;
         end
         if (wait_expired) fault_code <= FC_TIMEOUT;
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      adr_src   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      alu_src_b = 1'b0;
      reg_write = 1'b0;
      case (state)
         FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         MEMADR:   alu_src_b = 1'b1;
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         MEMWB:    reg_write = 1'b1;
         MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         default: ;
      endcase
   end

   assign fault = (state == FAULT);

endmodule

// File: tb/tb_ls_sequencer.sv
// tb_ls_sequencer: bench for ls_sequencer. Each instruction is planned as a
// per-cycle trace (inputs plus expected output vector) built from the
// instruction-level timing rules, then replayed against the DUT.
// Define LS_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_ls_sequencer;

   localparam int T = 16;
   localparam logic [6:0] LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011;
`ifdef LS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic [6:0] op = 7'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_b;
   logic       imm_src, reg_write, fault;
   logic [1:0] fault_code;
   logic [2:0] state_dbg;

   ls_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .alu_src_b  (alu_src_b),
      .imm_src    (imm_src),
      .reg_write  (reg_write),
      .fault      (fault),
      .fault_code (fault_code),
      .state_dbg  (state_dbg)
   );

   logic [10:0] obs;
   assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_b,
                 imm_src, reg_write, fault, fault_code};

   // scoreboard
   typedef struct packed {
      logic       rst;
      logic       rdy;
      logic [6:0] op;
   } stim_t;

   stim_t       stim_q[$];
   logic [10:0] exp_q[$];
   string       tag_q[$];
   int          total = 0;
   int          bad = 0;

   logic       m_imm = 1'b0;
   logic [1:0] m_code = 2'b00;
   logic [6:0] cur_op = 7'd0;

   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b exp=%b (req we adr irw pcw asb imm regw flt code)",
                  tag, got, exp);
      end
   endtask

   function automatic logic [10:0] v(input bit req, input bit we, input bit adr,
                                     input bit irw, input bit pcw, input bit asb,
                                     input bit regw, input bit flt, input logic [1:0] fc);
      return {req, we, adr, irw, pcw, asb, m_imm, regw, flt, fc};
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // driver tasks
   task automatic push(input logic r, input logic rdy, input logic [10:0] e, input string t);
      stim_q.push_back('{rst: r, rdy: rdy, op: cur_op});
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic drain();
      stim_t s;
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         rst = s.rst;
         mem_ready = s.rdy;
         op = s.op;
         @(negedge clk);
         check(tag_q.pop_front(), obs, exp_q.pop_front());
         @(posedge clk);
         #1;
      end
   endtask

   task automatic plan_reset(input logic [10:0] e_now, input string t);
      push(1'b1, rnd(), e_now, t);
      m_imm = 1'b0;
      m_code = 2'b00;
      push(1'b0, rnd(), v(0,0,0,0,0,0,0,0,2'b00), "boot");
   endtask

   task automatic plan_fault_then_reset(input int n);
      for (int i = 0; i < n; i++) push(1'b0, rnd(), v(0,0,0,0,0,0,0,1,m_code), "fault_hold");
      plan_reset(v(0,0,0,0,0,0,0,1,m_code), "fault_rst");
   endtask

   // w cycles of waiting then one ready cycle; a timeout-enabled build gives up
   // after T waiting cycles.
   task automatic plan_wait(input int w, input logic [10:0] e_wait, input logic [10:0] e_done,
                            input string t, output bit timed_out);
      timed_out = TO_EN && (w >= T);
      for (int i = 0; i < (timed_out ? T : w); i++) push(1'b0, 1'b0, e_wait, {t, "_wait"});
      if (!timed_out) push(1'b0, 1'b1, e_done, {t, "_done"});
      else m_code = 2'b10;
   endtask

   task automatic plan_instr(input logic [6:0] o, input int wf, input int wm, input bit rst_in_read);
      bit to;
      cur_op = o;
      plan_wait(wf, v(1,0,0,0,0,0,0,0,2'b00), v(1,0,0,1,1,0,0,0,2'b00), "fetch", to);
      if (to) begin
         plan_fault_then_reset(3);
         return;
      end
      push(1'b0, rnd(), v(0,0,0,0,0,0,0,0,2'b00), "decode");
      m_imm = (o == SW);
      if (o != LW && o != SW) begin
         m_code = 2'b01;
         plan_fault_then_reset(4);
         return;
      end
      push(1'b0, rnd(), v(0,0,0,0,0,1,0,0,2'b00), "memadr");
      if (o == LW) begin
         if (rst_in_read) begin
            push(1'b0, 1'b0, v(0,1,1,0,0,0,0,0,2'b00) ^ 11'b11000000000, "read_before_rst");
            plan_reset(v(1,0,1,0,0,0,0,0,2'b00), "read_rst");
            return;
         end
         plan_wait(wm, v(1,0,1,0,0,0,0,0,2'b00), v(1,0,1,0,0,0,0,0,2'b00), "read", to);
         if (to) begin
            plan_fault_then_reset(3);
            return;
         end
         push(1'b0, rnd(), v(0,0,0,0,0,0,1,0,2'b00), "memwb");
      end else begin
         plan_wait(wm, v(1,1,1,0,0,0,0,0,2'b00), v(1,1,1,0,0,0,0,0,2'b00), "write", to);
         if (to) plan_fault_then_reset(3);
      end
   endtask

   function automatic int rnd_wait();
      int r;
      r = $urandom_range(0, 9);
      if (r == 9) return T - 1;
      return (r < 5) ? 0 : $urandom_range(1, 3);
   endfunction

   initial begin
      logic [6:0] x;
      rst = 1'b1;
      @(posedge clk);
      #1;
      // second reset cycle and BOOT
      push(1'b1, rnd(), v(0,0,0,0,0,0,0,0,2'b00), "reset_hold");
      push(1'b0, rnd(), v(0,0,0,0,0,0,0,0,2'b00), "boot");
      drain();

      // LW zero-wait, SW with 3 wait cycles in MEMWRITE
      plan_instr(LW, 0, 0, 1'b0);
      plan_instr(SW, 0, 3, 1'b0);
      plan_instr(LW, 2, 1, 1'b0);
      drain();

      // reset while MEMREAD holds a request
      plan_instr(LW, 1, 0, 1'b1);
      drain();

      // illegal opcode (R-type)
      plan_instr(7'b0110011, 0, 0, 1'b0);
      drain();

      // long fetch wait: timeout build faults, default build keeps waiting
      plan_instr(LW, 40, 0, 1'b0);
      plan_instr(SW, 0, T, 1'b0);
      plan_instr(LW, 0, T + 2, 1'b0);
      plan_instr(SW, T - 1, T - 1, 1'b0);
      drain();

      // randomized instruction stream
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do x = 7'($urandom_range(0, 127)); while (x == LW || x == SW);
         end else begin
            x = rnd() ? SW : LW;
         end
         plan_instr(x, rnd_wait(), rnd_wait(), ($urandom_range(0, 19) == 0));
         drain();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
